insn_encoder: RTL and testbench
===============================

// Module: insn_encoder
// PURPOSE
//  Encodes RISC-V RV32I instruction fields (format, opcode, regs, funct, 32-bit signed imm) into 32-bit words.
//  Immediates are scattered into I/S/B/U/J bit positions, the exact inverse of immediate extraction in decode.
//  Range-checks each immediate, buffers results in a small FIFO and tags each word with a sequential
//  imem byte address. Sits between the self-test program source and the imem write port.
// PARAMETERS
//  DEPTH      2            output FIFO entries (power of 2, >=2)
//  AWIDTH     32           width of generated imem address
//  BASE_ADDR  32'h01000000 address assigned to first emitted word after reset
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       async active-low reset
//  in_valid   in   1       field bundle valid
//  in_ready   out  1       encoder can accept a bundle
//  fmt_i      in   3       0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//  opcode_i   in   7       inst[6:0]
//  rd_i       in   5       inst[11:7] (R/I/U/J)
//  rs1_i      in   5       inst[19:15] (R/I/S/B)
//  rs2_i      in   5       inst[24:20] (R/S/B)
//  funct3_i   in   3       inst[14:12] (R/I/S/B)
//  funct7_i   in   7       inst[31:25] (R only)
//  imm_i      in   32      signed byte immediate (U: full 32-bit value, low 12 bits must be 0)
//  out_valid  out  1       insn_o/addr_o valid
//  out_ready  in   1       sink accepts word
//  insn_o     out  32      encoded instruction
//  addr_o     out  AWIDTH  imem byte address of insn_o
//  err_o      out  1       1-cycle pulse: bundle rejected
//  err_cnt_o  out  8       rejected-bundle count, saturates at 255
// BEHAVIOUR
//  Reset (async assert, sync deassert): FIFO emptied, out_valid=0, insn_o=0, addr_o=BASE_ADDR,
//   err_o=0, err_cnt_o=0. Reset mid-transfer drops all buffered words. No partial output.
//  Accept: bundle taken on rising edge where in_valid&&in_ready. in_ready = (count<DEPTH).
//   in_ready is registered state only, no combinational path from out_ready.
//   A pop in the same cycle does not raise in_ready when full.
//  Encoding (fields outside a format are ignored):
//   R: {f7,rs2,rs1,f3,rd,op}   I: {imm[11:0],rs1,f3,rd,op}   S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
//   B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}   U: {imm[31:12],rd,op}
//   J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
//  Range rules, imm_i is signed 32-bit:
//   I/S: -2048..2047.  B: -4096..4094 and imm[0]=0.  J: -1048576..1048574 and imm[0]=0.
//   U: imm[11:0]==0.  R: imm ignored. fmt 6/7 always illegal.
//  Violation: bundle is still handshaken (consumed), not enqueued. err_o=1 on the cycle after accept.
//   err_cnt_o increments and holds at 255.
//  Latency: accepted legal bundle appears at head with out_valid=1 on the next cycle if FIFO was empty.
//   Otherwise it is queued in order.
//  Output: insn_o/addr_o hold stable while out_valid&&!out_ready. Pop on out_valid&&out_ready.
//   addr counter += 4 per pop, wraps modulo 2^AWIDTH. addr_o is the address of the head word.
//  Simultaneous push+pop with 0<count<DEPTH: count unchanged, order preserved.
//   Push+pop when empty: no bypass, word appears next cycle.
//  Empty: out_valid=0, insn_o holds last popped value.
// TESTING
//  I addi x1,x0,-1 (op 13,f3 0,imm FFFFFFFF) -> insn_o=FFF00093, addr_o=01000000, 1-cycle latency
//  S sw x2,8(x1) then B beq x0,x0,-4 back-to-back, out_ready=1 -> 0020A423 @01000000, FE000EE3 @01000004
//  J jal x1,2048 (op 6F) -> 001000EF; U lui x5 imm 12345000 (op 37) -> 123452B7
//  I imm=2048, B imm=3, U imm=00001001 -> nothing enqueued, three err_o pulses, err_cnt_o=3
//  out_ready=0, 3 legal pushes with DEPTH=2 -> in_ready=0 after 2 pushes.
//   Release -> words in order, addresses +4 each.
//  rst_n low mid-stream with 2 words queued -> out_valid=0 at once.
//   Next word after release gets addr_o=01000000.

Source files
------------

// File: rtl/insn_encoder.sv
// RV32I field-bundle encoder: packs format/opcode/regs/funct/imm into 32-bit words, tags each with an imem address.
// Latency: an accepted legal bundle reaches the head with out_valid one cycle later (no empty-FIFO bypass).
// Backpressure: in_ready = FIFO not full (registered count only); the head word and address hold while out_ready is low.
module insn_encoder #(
  parameter int                DEPTH     = 2,
  parameter int                AWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h0100_0000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt_i,
  input  logic [6:0]        opcode_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [31:0]       imm_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       insn_o,
  output logic [AWIDTH-1:0] addr_o,
  output logic              err_o,
  output logic [7:0]        err_cnt_o
);

  localparam int             PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW      = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [31:0]       mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [31:0]       last_q, last_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic [31:0] enc_insn;
  logic        enc_legal;
  logic        accept, push, pop;

  // A field is in range when every bit above its top bit equals the sign bit.
  logic imm_fits_12, imm_fits_13, imm_fits_21;
  assign imm_fits_12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign imm_fits_13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign imm_fits_21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

  // Scatter fields into the format's bit layout and judge the immediate range.
  always_comb begin
    enc_insn  = 32'h0;
    enc_legal = 1'b0;
    case (fmt_i)
      FMT_R: begin
        enc_insn  = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        enc_legal = 1'b1;
      end
      FMT_I: begin
        enc_insn  = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        enc_legal = imm_fits_12;
      end
      FMT_S: begin
        enc_insn  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        enc_legal = imm_fits_12;
      end
      FMT_B: begin
        enc_insn  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], opcode_i};
        enc_legal = imm_fits_13 & ~imm_i[0];
      end
      FMT_U: begin
        enc_insn  = {imm_i[31:12], rd_i, opcode_i};
        enc_legal = (imm_i[11:0] == 12'h000);
      end
      FMT_J: begin
        enc_insn  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        enc_legal = imm_fits_21 & ~imm_i[0];
      end
      default: begin
        enc_insn  = 32'h0;
        enc_legal = 1'b0;
      end
    endcase
  end

  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign accept    = in_valid & in_ready;
  assign push      = accept & enc_legal;
  assign pop       = out_valid & out_ready;

  // Next-state for pointers, occupancy, head address, last-popped word and error reporting.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    addr_d    = addr_q;
    last_d    = last_q;
    err_d     = accept & ~enc_legal;
    err_cnt_d = err_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      addr_d   = addr_q + AWIDTH'(4);
      last_d   = mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Control state; reset discards any buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      addr_q    <= BASE_ADDR;
      last_q    <= 32'h0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      last_q    <= last_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Word storage; contents are only meaningful under count_q, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc_insn;
  end

  // When empty the output keeps showing the most recently popped word.
  assign insn_o    = out_valid ? mem_q[rd_ptr_q] : last_q;
  assign addr_o    = addr_q;
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_insn_encoder.sv
module tb_insn_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt_i = 3'd0;
  logic [6:0]  opcode_i = 7'd0;
  logic [4:0]  rd_i = 5'd0, rs1_i = 5'd0, rs2_i = 5'd0;
  logic [2:0]  funct3_i = 3'd0;
  logic [6:0]  funct7_i = 7'd0;
  logic [31:0] imm_i = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] insn_o;
  logic [31:0] addr_o;
  logic        err_o;
  logic [7:0]  err_cnt_o;

  int n_cmp = 0;
  int n_fail = 0;

  insn_encoder #(.DEPTH(2), .AWIDTH(32), .BASE_ADDR(32'h0100_0000)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt_i(fmt_i), .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
    .out_valid(out_valid), .out_ready(out_ready), .insn_o(insn_o), .addr_o(addr_o),
    .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    fmt_i = f; opcode_i = op; rd_i = rd; rs1_i = r1; rs2_i = r2;
    funct3_i = f3; funct7_i = f7; imm_i = imm; in_valid = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (insn_o !== 32'h0) begin n_fail++; $display("FAIL rst_insn got %h want 00000000", insn_o); end
    n_cmp++; if (addr_o !== 32'h0100_0000) begin n_fail++; $display("FAIL rst_addr got %h want 01000000", addr_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", err_o); end
    n_cmp++; if (err_cnt_o !== 8'd0) begin n_fail++; $display("FAIL rst_err_cnt got %0d want 0", err_cnt_o); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_i_type();
    do_reset();
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL i_valid got %b want 1", out_valid); end
    n_cmp++; if (insn_o !== 32'hFFF0_0093) begin n_fail++; $display("FAIL i_insn got %h want FFF00093", insn_o); end
    n_cmp++; if (addr_o !== 32'h0100_0000) begin n_fail++; $display("FAIL i_addr got %h want 01000000", addr_o); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL i_empty got %b want 0", out_valid); end
    n_cmp++; if (insn_o !== 32'hFFF0_0093) begin n_fail++; $display("FAIL i_hold got %h want FFF00093", insn_o); end
    n_cmp++; if (addr_o !== 32'h0100_0004) begin n_fail++; $display("FAIL i_addr_inc got %h want 01000004", addr_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    drive(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    @(negedge clk);
    n_cmp++; if (insn_o !== 32'h0020_A423) begin n_fail++; $display("FAIL b2b_sw got %h want 0020A423", insn_o); end
    n_cmp++; if (addr_o !== 32'h0100_0000) begin n_fail++; $display("FAIL b2b_sw_addr got %h want 01000000", addr_o); end
    drive(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b want 1", out_valid); end
    n_cmp++; if (insn_o !== 32'hFE00_0EE3) begin n_fail++; $display("FAIL b2b_beq got %h want FE000EE3", insn_o); end
    n_cmp++; if (addr_o !== 32'h0100_0004) begin n_fail++; $display("FAIL b2b_beq_addr got %h want 01000004", addr_o); end
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_j_u_r();
    do_reset();
    out_ready = 1'b1;
    drive(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    @(negedge clk);
    n_cmp++; if (insn_o !== 32'h0010_00EF) begin n_fail++; $display("FAIL jal got %h want 001000EF", insn_o); end
    drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    @(negedge clk);
    n_cmp++; if (insn_o !== 32'h1234_52B7) begin n_fail++; $display("FAIL lui got %h want 123452B7", insn_o); end
    n_cmp++; if (addr_o !== 32'h0100_0004) begin n_fail++; $display("FAIL lui_addr got %h want 01000004", addr_o); end
    drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF);
    @(negedge clk);
    n_cmp++; if (insn_o !== 32'h4020_81B3) begin n_fail++; $display("FAIL sub got %h want 402081B3", insn_o); end
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (insn_o !== 32'h8000_0093) begin n_fail++; $display("FAIL i_min got %h want 80000093", insn_o); end
    n_cmp++; if (err_cnt_o !== 8'd0) begin n_fail++; $display("FAIL legal_no_err got %0d want 0", err_cnt_o); end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    do_reset();
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    @(negedge clk);
    n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL ill_i_err got %b want 1", err_o); end
    drive(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    @(negedge clk);
    n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL ill_b_err got %b want 1", err_o); end
    drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001);
    @(negedge clk);
    n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL ill_u_err got %b want 1", err_o); end
    n_cmp++; if (err_cnt_o !== 8'd3) begin n_fail++; $display("FAIL ill_cnt3 got %0d want 3", err_cnt_o); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ill_no_enq got %b want 0", out_valid); end
    drive(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    @(negedge clk);
    drive(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
    @(negedge clk);
    n_cmp++; if (err_cnt_o !== 8'd5) begin n_fail++; $display("FAIL ill_cnt5 got %0d want 5", err_cnt_o); end
    drive(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F000);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL b_min_err got %b want 0", err_o); end
    n_cmp++; if (insn_o !== 32'h8000_0063) begin n_fail++; $display("FAIL b_min got %h want 80000063", insn_o); end
    n_cmp++; if (err_cnt_o !== 8'd5) begin n_fail++; $display("FAIL cnt_hold got %0d want 5", err_cnt_o); end
  endtask

  task automatic test_err_saturate();
    do_reset();
    for (int i = 0; i < 260; i++) begin
      drive(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++; if (err_cnt_o !== 8'd255) begin n_fail++; $display("FAIL err_sat got %0d want 255", err_cnt_o); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL err_sat_enq got %b want 0", out_valid); end
  endtask

  task automatic test_full();
    do_reset();
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_rdy1 got %b want 1", in_ready); end
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_rdy2 got %b want 0", in_ready); end
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    @(negedge clk);
    n_cmp++; if (insn_o !== 32'h0010_0093) begin n_fail++; $display("FAIL full_hold got %h want 00100093", insn_o); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_stall got %b want 0", in_ready); end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (insn_o !== 32'h0020_0093) begin n_fail++; $display("FAIL full_w1 got %h want 00200093", insn_o); end
    n_cmp++; if (addr_o !== 32'h0100_0004) begin n_fail++; $display("FAIL full_a1 got %h want 01000004", addr_o); end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (insn_o !== 32'h0030_0093) begin n_fail++; $display("FAIL full_w2 got %h want 00300093", insn_o); end
    n_cmp++; if (addr_o !== 32'h0100_0008) begin n_fail++; $display("FAIL full_a2 got %h want 01000008", addr_o); end
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain got %b want 0", out_valid); end
    n_cmp++; if (addr_o !== 32'h0100_000C) begin n_fail++; $display("FAIL full_a3 got %h want 0100000C", addr_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    @(negedge clk);
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full got %b want 0", in_ready); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rdy got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (insn_o !== 32'h0050_0113) begin n_fail++; $display("FAIL mid_insn got %h want 00500113", insn_o); end
    n_cmp++; if (addr_o !== 32'h0100_0000) begin n_fail++; $display("FAIL mid_addr got %h want 01000000", addr_o); end
  endtask

  initial begin
    test_reset();
    test_i_type();
    test_back_to_back();
    test_j_u_r();
    test_illegal();
    test_err_saturate();
    test_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
